ham_enc_ser: RTL and testbench

//  Transmit-side Hamming(17,12) encoder with serial output; pairs with the team's 17-bit Hamming decoder.

---
 rtl/ham_pkg.sv | 43 ++++
 rtl/ham_enc17.sv | 26 ++
 rtl/ham_enc_ser.sv | 103 ++++++++++
 tb/tb_ham_enc_ser.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Hamming(17,12) constants and reference encoder, shared by encoder and decoder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ham_pkg;

  localparam int HAM_K = 12;
  localparam int HAM_N = 17;

  // Parity positions (1-based codeword positions)
  localparam int HAM_P1  = 1;
  localparam int HAM_P2  = 2;
  localparam int HAM_P4  = 4;
  localparam int HAM_P8  = 8;
  localparam int HAM_P16 = 16;

  // Beat index of the final serial bit in a frame
  localparam logic [4:0] HAM_LAST_BEAT = 5'(HAM_N - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Data bits occupy non-power-of-two positions; cw[i] is position i+1.
  function automatic logic [HAM_N-1:0] ham17_encode(input logic [HAM_K-1:0] d);
    logic [HAM_N-1:0] c;
    c       = '0;
    c[2]    = d[0];
    c[4]    = d[1];
    c[5]    = d[2];
    c[6]    = d[3];
    c[8]    = d[4];
    c[14:9] = d[10:5];
    c[16]   = d[11];
    c[0]    = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14] ^ c[16];
    c[1]    = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
    c[3]    = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    c[7]    = ^c[14:8];
    c[15]   = c[16];
    return c;
  endfunction

endpackage

// File: rtl/ham_enc17.sv
// Combinational Hamming(17,12) encoder with optional single-bit error injection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module ham_enc17
  import ham_pkg::*;
#(
  parameter bit INJ_EN = 1'b1
) (
  input  logic [HAM_K-1:0] data,
  input  logic [4:0]       inj_pos,
  output logic [HAM_N-1:0] cw
);

  logic [HAM_N-1:0] flip;

  // One-hot flip mask for positions 1..17; anything else (or injection disabled) leaves the word intact
  always_comb begin
    flip = '0;
    if (INJ_EN && (inj_pos >= 5'd1) && (inj_pos <= 5'(HAM_N))) begin
      flip = HAM_N'(1) << (inj_pos - 5'd1);
    end
  end

  assign cw = ham17_encode(data) ^ flip;

endmodule

// File: rtl/ham_enc_ser.sv
// Hamming(17,12) encoder feeding a 1-deep hold buffer and an LSB-first 17-beat serializer.
// Latency: word accepted at edge N shows tx_valid/tx_sof after edge N+1; back-to-back frames have no gap.
// Backpressure: tx_ready low freezes all tx outputs; in_ready is low while the hold buffer is full.
module ham_enc_ser
  import ham_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter bit INJ_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_data,
  input  logic [4:0]       in_inj_pos,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_bit,
  output logic             tx_sof,
  output logic             tx_eof,
  output logic [16:0]      tx_cw,
  output logic [CNT_W-1:0] frame_cnt
);

  ser_state_t       state, state_nxt;
  logic             hold_v;
  logic [HAM_N-1:0] hold_cw;
  logic [HAM_N-1:0] enc_cw;
  logic [HAM_N-1:0] shift_cw;
  logic [4:0]       beat;
  logic             accept;
  logic             fire;
  logic             last;
  logic             load;

  ham_enc17 #(.INJ_EN(INJ_EN)) u_enc (
    .data    (in_data),
    .inj_pos (in_inj_pos),
    .cw      (enc_cw)
  );

  assign in_ready = ~hold_v;
  assign accept   = in_valid & in_ready;
  assign tx_valid = (state == ST_SHIFT);
  assign fire     = tx_valid & tx_ready;
  assign last     = fire & (beat == HAM_LAST_BEAT);
  // HOLD drains into the shifter when it is idle or completing its final beat
  assign load     = hold_v & ((state == ST_IDLE) | last);

  assign tx_bit = tx_valid & shift_cw[beat];
  assign tx_sof = tx_valid & (beat == 5'd0);
  assign tx_eof = tx_valid & (beat == HAM_LAST_BEAT);
  assign tx_cw  = shift_cw;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: start on a full hold buffer, return to idle only when a frame ends with nothing queued
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (hold_v) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last && !hold_v) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Hold buffer: capture encoded word on accept, clear when moved to the shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v  <= 1'b0;
      hold_cw <= '0;
    end else begin
      if (accept) hold_cw <= enc_cw;
      hold_v <= accept | (hold_v & ~load);
    end
  end

  // Shifter: reload at beat 0 from HOLD, otherwise advance one beat per handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_cw <= '0;
      beat     <= 5'd0;
    end else if (load) begin
      shift_cw <= hold_cw;
      beat     <= 5'd0;
    end else if (last) begin
      beat     <= 5'd0;
    end else if (fire) begin
      beat     <= beat + 5'd1;
    end
  end

  // Frame counter: one count per completed frame, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       frame_cnt <= '0;
    else if (last) frame_cnt <= frame_cnt + 1'b1;
  end

endmodule

// File: tb/tb_ham_enc_ser.sv
// Directed self-checking bench for ham_enc_ser: serial capture, scoreboard, stall and reset checks.
// Inputs driven and outputs sampled on the falling edge; DUT registers on the rising edge.
// Expected codewords come from an independent position-loop encoder and hand-computed constants.
module tb_ham_enc_ser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic [4:0]  in_inj_pos;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_bit;
  logic        tx_sof;
  logic        tx_eof;
  logic [16:0] tx_cw;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  ham_enc_ser #(.CNT_W(16), .INJ_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_inj_pos (in_inj_pos),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_bit     (tx_bit),
    .tx_sof     (tx_sof),
    .tx_eof     (tx_eof),
    .tx_cw      (tx_cw),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent encoder: walk positions 1..17, fill data slots in order, then even parity per bit
  function automatic logic [16:0] ref_enc(input logic [11:0] d);
    logic [16:0] c;
    int k;
    int pp;
    logic x;
    c = '0;
    k = 0;
    for (int p = 1; p <= 17; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      pp = 1 << b;
      x  = 1'b0;
      for (int p = 1; p <= 17; p++)
        if (((p & pp) != 0) && (p != pp)) x = x ^ c[p-1];
      c[pp-1] = x;
    end
    return c;
  endfunction

  function automatic logic [16:0] flip_mask(input logic [4:0] p);
    logic [16:0] m;
    m = '0;
    if (p >= 5'd1 && p <= 5'd17) m[p-5'd1] = 1'b1;
    return m;
  endfunction

  // Syndrome decoder: XOR of set positions, correct one bit, gather data slots
  task automatic dec(input logic [16:0] cw, output logic [11:0] d, output logic [4:0] syn);
    logic [16:0] c;
    int k;
    c   = cw;
    syn = '0;
    for (int p = 1; p <= 17; p++) if (c[p-1]) syn = syn ^ 5'(p);
    if (syn >= 5'd1 && syn <= 5'd17) c[syn-5'd1] = ~c[syn-5'd1];
    k = 0;
    d = '0;
    for (int p = 1; p <= 17; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
  endtask

  // Offer one word (called on a falling edge); returns on the falling edge after the accepting edge
  task automatic send(input logic [11:0] d, input logic [4:0] inj, output bit ok);
    int n;
    n          = 0;
    in_valid   = 1'b1;
    in_data    = d;
    in_inj_pos = inj;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Collect one 17-beat frame from the serial port, optionally stalling at random
  task automatic recv(input bit rnd, output logic [16:0] ser, output logic [16:0] par,
                      output bit first_v, output int bad_flags, output int stalls_bad,
                      output bit tmo);
    int beats;
    int cyc;
    bit pstall;
    logic [20:0] prev;
    logic [20:0] cur;
    beats = 0; cyc = 0; pstall = 1'b0; prev = '0;
    ser = '0; par = '0; bad_flags = 0; stalls_bad = 0;
    first_v = tx_valid;
    while (beats < 17 && cyc < 3000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cur = {tx_valid, tx_bit, tx_sof, tx_eof, tx_cw};
      if (pstall && cur !== prev) stalls_bad++;
      if (tx_valid && tx_ready) begin
        ser[beats] = tx_bit;
        if (beats == 0) par = tx_cw;
        if (tx_sof !== (beats == 0) || tx_eof !== (beats == 16)) bad_flags++;
        beats++;
      end
      pstall = tx_valid && !tx_ready;
      prev   = cur;
      @(negedge clk);
      cyc++;
    end
    tmo = (beats < 17);
  endtask

  task automatic frame_chk(input string tag, input logic [11:0] d, input logic [4:0] inj,
                           input logic [16:0] exp);
    bit ok, fv, tmo;
    logic [16:0] ser, par;
    int bf, sb;
    send(d, inj, ok);
    chk({tag, "_acc"}, 32'(ok), 32'd1);
    recv(1'b0, ser, par, fv, bf, sb, tmo);
    chk({tag, "_tmo"}, 32'(tmo), 32'd0);
    chk({tag, "_ser"}, 32'(ser), 32'(exp));
    chk({tag, "_par"}, 32'(par), 32'(exp));
    chk({tag, "_flags"}, 32'(bf), 32'd0);
  endtask

  initial begin
    logic [16:0] ser1, par1, ser2, par2, exp_cw;
    logic [11:0] dd;
    logic [4:0]  syn;
    logic [15:0] base;
    logic [16:0] expq[$];
    bit ok, fv1, fv2, tmo1, tmo2;
    int bf1, bf2, sb1, sb2;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inj_pos = '0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_tx_valid", 32'(tx_valid), 32'd0);
    chk("rel_tx_bit",   32'(tx_bit),   32'd0);
    chk("rel_sof",      32'(tx_sof),   32'd0);
    chk("rel_eof",      32'(tx_eof),   32'd0);
    chk("rel_tx_cw",    32'(tx_cw),    32'd0);
    chk("rel_frame_cnt",32'(frame_cnt),32'd0);

    // Test 1: latency, all-zero frame, frame count
    send(12'h000, 5'd0, ok);
    chk("t1_acc", 32'(ok), 32'd1);
    chk("t1_lat_n", 32'(tx_valid), 32'd0);
    chk("t1_hold_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t1_lat_valid", 32'(tx_valid), 32'd1);
    chk("t1_lat_sof", 32'(tx_sof), 32'd1);
    recv(1'b0, ser1, par1, fv1, bf1, sb1, tmo1);
    chk("t1_tmo", 32'(tmo1), 32'd0);
    chk("t1_ser", 32'(ser1), 32'd0);
    chk("t1_flags", 32'(bf1), 32'd0);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_idle", 32'(tx_valid), 32'd0);

    // Test 2/3: hand-computed codewords, then injected error and correction
    frame_chk("t2_001", 12'h001, 5'd0, 17'h00007);
    frame_chk("t2_fff", 12'hFFF, 5'd0, 17'h1FFFE);
    frame_chk("t2_fff_inj20", 12'hFFF, 5'd20, 17'h1FFFE);
    frame_chk("t3_fff_inj9", 12'hFFF, 5'd9, 17'h1FEFE);
    dec(17'h1FEFE, dd, syn);
    chk("t3_dec_data", 32'(dd), 32'hFFF);
    chk("t3_dec_syn", 32'(syn), 32'd9);
    frame_chk("t3_000_inj17", 12'h000, 5'd17, 17'h10000);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd6);

    // Test 4: back-to-back words, no gap between frames
    base = frame_cnt;
    tx_ready = 1'b1;
    fork
      begin
        bit ok_a, ok_b;
        send(12'h5A5, 5'd0, ok_a);
        send(12'h3C3, 5'd0, ok_b);
        chk("t4_acc_a", 32'(ok_a), 32'd1);
        chk("t4_acc_b", 32'(ok_b), 32'd1);
        chk("t4_in_ready_low", 32'(in_ready), 32'd0);
      end
      begin
        recv(1'b0, ser1, par1, fv1, bf1, sb1, tmo1);
        recv(1'b0, ser2, par2, fv2, bf2, sb2, tmo2);
      end
    join
    chk("t4_f1_ser", 32'(ser1), 32'(ref_enc(12'h5A5)));
    chk("t4_f2_ser", 32'(ser2), 32'(ref_enc(12'h3C3)));
    chk("t4_f2_par", 32'(par2), 32'(ref_enc(12'h3C3)));
    chk("t4_no_gap", 32'(fv2), 32'd1);
    chk("t4_flags", 32'(bf1 + bf2), 32'd0);
    chk("t4_tmo", 32'(tmo1 | tmo2), 32'd0);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'(base + 16'd2));

    // Test 5: 100 frames with random stalls and random injection
    base = frame_cnt;
    fork
      begin
        logic [11:0] d;
        logic [4:0]  inj;
        bit sok;
        for (int i = 0; i < 100; i++) begin
          d   = 12'($urandom);
          inj = 5'($urandom_range(0, 31));
          expq.push_back(ref_enc(d) ^ flip_mask(inj));
          send(d, inj, sok);
          chk("t5_acc", 32'(sok), 32'd1);
        end
      end
      begin
        for (int i = 0; i < 100; i++) begin
          recv(1'b1, ser1, par1, fv1, bf1, sb1, tmo1);
          exp_cw = (expq.size() > 0) ? expq.pop_front() : 17'h0;
          chk("t5_ser", 32'(ser1), 32'(exp_cw));
          chk("t5_par", 32'(par1), 32'(exp_cw));
          chk("t5_stall_stable", 32'(sb1), 32'd0);
          chk("t5_flags", 32'(bf1), 32'd0);
          chk("t5_tmo", 32'(tmo1), 32'd0);
        end
      end
    join
    chk("t5_frame_cnt", 32'(frame_cnt), 32'(base + 16'd100));

    // Test 6: reset at beat 8 with HOLD full
    tx_ready = 1'b0;
    @(negedge clk);
    send(12'hFFF, 5'd0, ok);
    send(12'h123, 5'd0, ok);
    chk("t6_hold_full", 32'(in_ready), 32'd0);
    chk("t6_sof_wait", 32'(tx_sof), 32'd1);
    tx_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_beat8_bit", 32'(tx_bit), 32'd1);
    rst = 1'b1;
    tx_ready = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(tx_valid), 32'd0);
    chk("t6_rst_bit", 32'(tx_bit), 32'd0);
    chk("t6_rst_sof", 32'(tx_sof), 32'd0);
    chk("t6_rst_eof", 32'(tx_eof), 32'd0);
    chk("t6_rst_cw", 32'(tx_cw), 32'd0);
    chk("t6_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_rst_in_ready2", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_resume", 32'(tx_valid), 32'd0);
    chk("t6_no_resume_cnt", 32'(frame_cnt), 32'd0);
    send(12'h001, 5'd0, ok);
    chk("t6_fresh_acc", 32'(ok), 32'd1);
    @(negedge clk);
    chk("t6_fresh_sof", 32'(tx_sof), 32'd1);
    recv(1'b0, ser1, par1, fv1, bf1, sb1, tmo1);
    chk("t6_fresh_ser", 32'(ser1), 32'h00007);
    chk("t6_fresh_cnt", 32'(frame_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
